// File: rtl/fetch_prefetch_unit_if.sv
// fetch_prefetch_unit_if: instruction-memory, redirect and output handshake bundle for the fetch unit
// master: the fetch unit (drives imem_req/imem_addr and the out_* stream)
// slave : the environment (memory returns imem_rdata, stage 3 drives redirect_*, stage 1 drives out_ready)
interface fetch_prefetch_unit_if #(
    parameter int DEPTH   = 4,
    parameter int IMEM_AW = 10
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic [15:0]        imem_rdata;
    logic               redirect_valid;
    logic [15:0]        redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        out_instruction;
    logic [15:0]        out_pc;
    logic [CW-1:0]      fifo_count;
    modport master (
        output imem_req, imem_addr, out_valid, out_instruction, out_pc, fifo_count,
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );
    modport slave (
        input  imem_req, imem_addr, out_valid, out_instruction, out_pc, fifo_count,
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: PC owner and prefetch FIFO feeding stage 1 of the 16-bit pipeline
// CLK : clock, rising edge
// RST : asynchronous active-low reset
// bus : fetch_prefetch_unit_if.master -- imem read port, redirect input, valid/ready output stream, occupancy
module fetch_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          IMEM_AW  = 10
) (
    input logic                   CLK,
    input logic                   RST,
    fetch_prefetch_unit_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [15:0]   pc;
    logic [15:0]   inflight_pc;
    logic          inflight;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [15:0]   fifo_instr [DEPTH];
    logic [15:0]   fifo_pc    [DEPTH];
    logic          issue;
    logic          push;
    logic          pop;
    logic          not_empty;
    // Issue counts the in-flight read as occupied and ignores a same-cycle pop,
    // so the response always has a free slot when it lands.
    always_comb begin
        not_empty = count != '0;
        issue     = RST && !bus.redirect_valid && ((count + CW'(inflight)) < CW'(DEPTH));
        push      = inflight && !bus.redirect_valid;
        pop       = not_empty && bus.out_ready;
    end
    assign bus.imem_req        = issue;
    assign bus.imem_addr       = pc[IMEM_AW-1:0];
    assign bus.out_valid       = not_empty;
    assign bus.fifo_count      = count;
    assign bus.out_instruction = not_empty ? fifo_instr[rd_ptr] : 16'h0000;
    assign bus.out_pc          = not_empty ? fifo_pc[rd_ptr] : 16'h0000;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 16'h0000;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (bus.redirect_valid) begin
            pc       <= bus.redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            pc          <= issue ? pc + 16'd1 : pc;
            inflight    <= issue;
            inflight_pc <= issue ? pc : inflight_pc;
            rd_ptr      <= pop ? rd_ptr + PW'(1) : rd_ptr;
            wr_ptr      <= push ? wr_ptr + PW'(1) : wr_ptr;
            count       <= count + CW'(push) - CW'(pop);
        end
    end
    // Payload storage needs no reset: it is only observed through count.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_instr[wr_ptr] <= bus.imem_rdata;
            fifo_pc[wr_ptr]    <= inflight_pc;
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed stimulus with a queue-based reference model and per-cycle compare
module tb_fetch_prefetch_unit;
    localparam int DEPTH = 4;
    logic CLK;
    logic RST;
    int   checks = 0;
    int   errors = 0;
    fetch_prefetch_unit_if #(.DEPTH(DEPTH), .IMEM_AW(10)) bus ();
    fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'h0000), .IMEM_AW(10)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );
    function automatic logic [15:0] memf(input logic [9:0] a);
        return 16'hB400 | {6'b0, a};
    endfunction
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
    always @(posedge CLK) bus.imem_rdata <= bus.imem_req ? memf(bus.imem_addr) : 16'hDEAD;
    logic [15:0] mpc = 16'h0000;
    logic [15:0] minfl_pc = 16'h0000;
    logic        minfl = 1'b0;
    logic [15:0] mq_pc [$];
    logic [15:0] mq_ins [$];
    initial begin
        forever begin
            @(posedge CLK or negedge RST);
            if (!RST) begin
                mpc = 16'h0000;
                minfl = 1'b0;
                minfl_pc = 16'h0000;
                mq_pc.delete();
                mq_ins.delete();
            end else if (bus.redirect_valid) begin
                mpc = bus.redirect_pc;
                minfl = 1'b0;
                mq_pc.delete();
                mq_ins.delete();
            end else begin
                automatic int  n   = mq_pc.size();
                automatic bit  iss = (n + int'(minfl)) < DEPTH;
                if (n != 0 && bus.out_ready) begin
                    void'(mq_pc.pop_front());
                    void'(mq_ins.pop_front());
                end
                if (minfl) begin
                    mq_pc.push_back(minfl_pc);
                    mq_ins.push_back(memf(minfl_pc[9:0]));
                end
                minfl = iss;
                if (iss) begin
                    minfl_pc = mpc;
                    mpc = mpc + 16'd1;
                end
            end
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask
    always @(negedge CLK) begin
        automatic int n = mq_pc.size();
        chk("m_valid", 32'(bus.out_valid), 32'(n != 0));
        chk("m_count", 32'(bus.fifo_count), 32'(n));
        chk("m_pc", 32'(bus.out_pc), n != 0 ? 32'(mq_pc[0]) : 32'h0);
        chk("m_instr", 32'(bus.out_instruction), n != 0 ? 32'(mq_ins[0]) : 32'h0);
        chk("m_req", 32'(bus.imem_req), 32'(RST && !bus.redirect_valid && (n + int'(minfl)) < DEPTH));
        chk("m_addr", 32'(bus.imem_addr), 32'(mpc[9:0]));
    end
    task automatic step(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask
    initial begin
        int budget;
        RST = 1'b0;
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 16'h0000;
        step(2);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_count", 32'(bus.fifo_count), 32'h0);
        chk("rst_req", 32'(bus.imem_req), 32'h0);
        chk("rst_pc", 32'(bus.out_pc), 32'h0);
        RST = 1'b1;
        #1;
        chk("rel_req", 32'(bus.imem_req), 32'h1);
        chk("rel_addr", 32'(bus.imem_addr), 32'h0);
        step(1);
        chk("lat1_valid", 32'(bus.out_valid), 32'h0);
        step(1);
        chk("lat2_valid", 32'(bus.out_valid), 32'h1);
        chk("lat2_pc", 32'(bus.out_pc), 32'h0);
        chk("lat2_instr", 32'(bus.out_instruction), 32'hB400);
        step(6);
        chk("stream_pc", 32'(bus.out_pc), 32'h6);
        chk("stream_instr", 32'(bus.out_instruction), 32'hB406);
        RST = 1'b0;
        #1;
        chk("async_valid", 32'(bus.out_valid), 32'h0);
        chk("async_count", 32'(bus.fifo_count), 32'h0);
        bus.out_ready = 1'b0;
        step(1);
        RST = 1'b1;
        step(10);
        chk("full_count", 32'(bus.fifo_count), 32'h4);
        chk("full_req", 32'(bus.imem_req), 32'h0);
        chk("full_pc", 32'(bus.out_pc), 32'h0);
        chk("full_instr", 32'(bus.out_instruction), 32'hB400);
        chk("full_addr", 32'(bus.imem_addr), 32'h4);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("drain_pc", 32'(bus.out_pc), 32'(i));
            chk("drain_valid", 32'(bus.out_valid), 32'h1);
            step(1);
        end
        bus.out_ready = 1'b0;
        budget = 0;
        while (bus.fifo_count != 3 && budget < 20) begin
            step(1);
            budget++;
        end
        chk("reach_count3", 32'(bus.fifo_count), 32'h3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0040;
        bus.out_ready = 1'b1;
        #1;
        chk("redir_req", 32'(bus.imem_req), 32'h0);
        step(1);
        bus.redirect_valid = 1'b0;
        #1;
        chk("redir_count", 32'(bus.fifo_count), 32'h0);
        chk("redir_valid", 32'(bus.out_valid), 32'h0);
        chk("redir_issue", 32'(bus.imem_req), 32'h1);
        chk("redir_addr", 32'(bus.imem_addr), 32'h40);
        step(1);
        chk("redir_bubble", 32'(bus.out_valid), 32'h0);
        step(1);
        chk("redir_pc0", 32'(bus.out_pc), 32'h40);
        chk("redir_instr0", 32'(bus.out_instruction), 32'hB440);
        step(1);
        chk("redir_pc1", 32'(bus.out_pc), 32'h41);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h1234;
        step(1);
        bus.redirect_pc = 16'hFFFE;
        step(1);
        bus.redirect_valid = 1'b0;
        #1;
        chk("wrap_addr0", 32'(bus.imem_addr), 32'h3FE);
        chk("wrap_req0", 32'(bus.imem_req), 32'h1);
        step(1);
        chk("wrap_addr1", 32'(bus.imem_addr), 32'h3FF);
        step(1);
        chk("wrap_addr2", 32'(bus.imem_addr), 32'h000);
        chk("wrap_pc0", 32'(bus.out_pc), 32'hFFFE);
        chk("wrap_instr0", 32'(bus.out_instruction), 32'hB7FE);
        step(1);
        chk("wrap_addr3", 32'(bus.imem_addr), 32'h001);
        chk("wrap_pc1", 32'(bus.out_pc), 32'hFFFF);
        step(1);
        chk("wrap_pc2", 32'(bus.out_pc), 32'h0000);
        chk("wrap_instr2", 32'(bus.out_instruction), 32'hB400);
        step(1);
        chk("wrap_pc3", 32'(bus.out_pc), 32'h0001);
        bus.out_ready = 1'b0;
        step(2);
        chk("pre_rst_count", 32'(bus.fifo_count), 32'h3);
        #2;
        RST = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("mid_rst_count", 32'(bus.fifo_count), 32'h0);
        chk("mid_rst_req", 32'(bus.imem_req), 32'h0);
        step(1);
        RST = 1'b1;
        #1;
        chk("restart_req", 32'(bus.imem_req), 32'h1);
        chk("restart_addr", 32'(bus.imem_addr), 32'h0);
        bus.out_ready = 1'b1;
        step(2);
        chk("restart_valid", 32'(bus.out_valid), 32'h1);
        chk("restart_pc", 32'(bus.out_pc), 32'h0);
        step(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
